// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer plus counter-qualified debounce FSM with bounce counter
module key_debounce #(
  parameter int   DEB_CYCLES = 500000,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       glitch_clr,
  output logic       key_out,
  output logic       key_busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam state_t           IDLE_INIT = INIT_LEVEL ? IDLE_HI : IDLE_LO;
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_a;
  logic             key_sync;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_nxt;
  logic             busy_nxt;
  logic             reject;
  logic [7:0]       glitch_nxt;

  // Two-flop synchronizer; nothing downstream looks at key_in directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a   <= INIT_LEVEL;
      key_sync <= INIT_LEVEL;
    end else begin
      sync_a   <= key_in;
      key_sync <= sync_a;
    end
  end

  // State register together with the registered counter and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE_INIT;
      cnt        <= '0;
      key_out    <= INIT_LEVEL;
      key_busy   <= 1'b0;
      glitch_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      key_out    <= out_nxt;
      key_busy   <= busy_nxt;
      glitch_cnt <= glitch_nxt;
    end
  end

  // Next-state: leave idle on a differing sample, leave wait on abort or full qualification
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_LO: if (key_sync) state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (!key_sync)           state_nxt = IDLE_LO;
        else if (cnt == DEB_MAX) state_nxt = IDLE_HI;
      end
      IDLE_HI: if (!key_sync) state_nxt = WAIT_LO;
      WAIT_LO: begin
        if (key_sync)            state_nxt = IDLE_HI;
        else if (cnt == DEB_MAX) state_nxt = IDLE_LO;
      end
      default: state_nxt = IDLE_INIT;
    endcase
  end

  // Next values of counter, level, busy flag and the rejection pulse
  always_comb begin
    cnt_nxt  = cnt;
    out_nxt  = key_out;
    busy_nxt = key_busy;
    reject   = 1'b0;
    case (state)
      IDLE_LO: begin
        if (key_sync) begin
          cnt_nxt  = CNT_ONE;
          busy_nxt = 1'b1;
        end else begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
      WAIT_HI: begin
        if (!key_sync) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          reject   = 1'b1;
        end else if (cnt == DEB_MAX) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          out_nxt  = 1'b1;
        end else begin
          cnt_nxt  = cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!key_sync) begin
          cnt_nxt  = CNT_ONE;
          busy_nxt = 1'b1;
        end else begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
      WAIT_LO: begin
        if (key_sync) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          reject   = 1'b1;
        end else if (cnt == DEB_MAX) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
          out_nxt  = 1'b0;
        end else begin
          cnt_nxt  = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt  = '0;
        busy_nxt = 1'b0;
        out_nxt  = INIT_LEVEL;
      end
    endcase
  end

  // Saturating bounce counter; a clear in the same cycle as a rejection wins
  always_comb begin
    glitch_nxt = glitch_cnt;
    if (glitch_clr)
      glitch_nxt = 8'd0;
    else if (reject && glitch_cnt != 8'hFF)
      glitch_nxt = glitch_cnt + 8'd1;
  end

endmodule
